// File: rtl/warpv_l15_bridge.sv
// WARP-V memory port to OpenPiton L1.5 bridge, single outstanding request.
// Optional atomics (SWAP_RQ / ATOMIC_RES) under `WARPV_L15_AMO_EN.
module warpv_l15_bridge #(
  parameter int XLEN           = 32,
  parameter int PHY_ADDR_WIDTH = 40,
  parameter int NC_BIT         = XLEN - 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      core_req_valid,
  output logic                      core_req_ready,
  input  logic [XLEN-1:0]           core_req_addr,
  input  logic [XLEN-1:0]           core_req_wdata,
  input  logic [XLEN/8-1:0]         core_req_wstrb,
  input  logic [3:0]                core_req_amo_op,
  output logic                      core_rsp_valid,
  output logic [XLEN-1:0]           core_rsp_rdata,
  output logic                      core_rsp_err,
  output logic                      transducer_l15_val,
  output logic [4:0]                transducer_l15_rqtype,
  output logic [2:0]                transducer_l15_size,
  output logic [PHY_ADDR_WIDTH-1:0] transducer_l15_address,
  output logic [63:0]               transducer_l15_data,
  output logic                      transducer_l15_nc,
  output logic [3:0]                transducer_l15_amo_op,
  output logic                      transducer_l15_threadid,
  output logic                      transducer_l15_prefetch,
  output logic                      transducer_l15_invalidate_cacheline,
  output logic                      transducer_l15_blockstore,
  output logic                      transducer_l15_blockinitstore,
  output logic [1:0]                transducer_l15_l1rplway,
  output logic [63:0]               transducer_l15_data_next_entry,
  output logic [32:0]               transducer_l15_csm_data,
  input  logic                      l15_transducer_ack,
  input  logic                      l15_transducer_header_ack,
  input  logic                      l15_transducer_val,
  input  logic [3:0]                l15_transducer_returntype,
  input  logic [63:0]               l15_transducer_data_0,
  input  logic [63:0]               l15_transducer_data_1,
  output logic                      transducer_l15_req_ack,
  output logic                      warpv_int
);

  localparam int SW = XLEN / 8;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] STORE_RQ = 5'b00001;
  localparam logic [4:0] SWAP_RQ  = 5'b00110;

  localparam logic [3:0] LOAD_RET   = 4'b0000;
  localparam logic [3:0] ST_ACK     = 4'b0100;
  localparam logic [3:0] INT_RET    = 4'b0111;
  localparam logic [3:0] ATOMIC_RES = 4'b1110;

  // {legal, size}: legal is 0 / aligned run of 1,2,4,8 bytes
  function automatic logic [3:0] strb_dec(input logic [SW-1:0] s);
    logic [3:0]    r;
    logic [SW-1:0] pat;
    int            n;
    r = (s == '0) ? 4'b1000 : 4'b0000;
    for (int lg = 0; lg < 4; lg++) begin
      n = 1 << lg;
      for (int o = 0; o < SW; o++) begin
        for (int b = 0; b < SW; b++)
          pat[b] = (b >= o) && (b < o + n);
        if (n <= SW && (o % n) == 0 &&
            (o + n) <= SW && s == pat)
          r = {1'b1, 3'(lg + 1)};
      end
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] bswap(
    input logic [XLEN-1:0] d
  );
    logic [XLEN-1:0] r;
    for (int i = 0; i < SW; i++)
      r[8*i +: 8] = d[XLEN-8-8*i +: 8];
    return r;
  endfunction

  logic [1:0]      state;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic [3:0]      amo_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;
  logic            int_q;

  logic [3:0]      in_dec;
  logic [3:0]      q_dec;
  logic            is_amo;
  logic [3:0]      amo_fwd;
  logic [PHY_ADDR_WIDTH-1:0] paddr;
  logic [63:0]     st_word;
  logic [XLEN-1:0] ld_word;
  logic            rsp_hit;
  logic            rsp_ld;
  logic            timeout;
  logic            unused_ok;

  assign in_dec = strb_dec(core_req_wstrb);
  assign q_dec  = strb_dec(wstrb_q);

`ifdef WARPV_L15_AMO_EN
  assign is_amo    = (amo_q != 4'd0) && (wstrb_q != '0);
  assign amo_fwd   = is_amo ? amo_q : 4'd0;
  assign unused_ok = l15_transducer_header_ack;
`else
  assign is_amo    = 1'b0;
  assign amo_fwd   = 4'd0;
  assign unused_ok = ^{l15_transducer_header_ack, amo_q};
`endif

  if (PHY_ADDR_WIDTH > XLEN) begin : g_sext
    assign paddr = {{(PHY_ADDR_WIDTH-XLEN){addr_q[XLEN-1]}}, addr_q};
  end else begin : g_trunc
    assign paddr = addr_q[PHY_ADDR_WIDTH-1:0];
  end

  if (XLEN == 32) begin : g_x32
    logic [31:0] sw;
    assign sw      = bswap(wdata_q);
    assign st_word = {sw, sw};
    always_comb begin
      ld_word = '0;
      unique case (addr_q[3:2])
        2'b00:   ld_word = l15_transducer_data_0[63:32];
        2'b01:   ld_word = l15_transducer_data_0[31:0];
        2'b10:   ld_word = l15_transducer_data_1[63:32];
        default: ld_word = l15_transducer_data_1[31:0];
      endcase
    end
  end else begin : g_x64
    assign st_word = bswap(wdata_q);
    assign ld_word = addr_q[3] ? l15_transducer_data_1
                               : l15_transducer_data_0;
  end

  always_comb begin
    rsp_hit = 1'b0;
    rsp_ld  = 1'b0;
    if (l15_transducer_val) begin
      unique case (1'b1)
        (l15_transducer_returntype == LOAD_RET): begin
          rsp_hit = 1'b1;
          rsp_ld  = 1'b1;
        end
        (l15_transducer_returntype == ST_ACK):
          rsp_hit = 1'b1;
`ifdef WARPV_L15_AMO_EN
        (l15_transducer_returntype == ATOMIC_RES): begin
          rsp_hit = 1'b1;
          rsp_ld  = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      amo_q   <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      int_q   <= 1'b0;
    end else begin
      int_q <= l15_transducer_val &&
               l15_transducer_returntype == INT_RET &&
               l15_transducer_data_0[17:16] == 2'b01;
      unique case (state)
        S_IDLE: if (core_req_valid) begin
          addr_q  <= core_req_addr;
          wdata_q <= core_req_wdata;
          wstrb_q <= core_req_wstrb;
          amo_q   <= core_req_amo_op;
          if (in_dec[3]) begin
            state <= S_REQ;
          end else begin
            state   <= S_RESP;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        S_REQ: if (l15_transducer_ack) begin
          state <= S_WAIT;
          cnt   <= '0;
        end
        S_WAIT: begin
          if (rsp_hit) begin
            state   <= S_RESP;
            err_q   <= 1'b0;
            rdata_q <= rsp_ld ? bswap(ld_word) : '0;
          end else if (timeout) begin
            state   <= S_RESP;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign core_req_ready = rst_n && state == S_IDLE;
  assign core_rsp_valid = state == S_RESP;
  assign core_rsp_rdata = rdata_q;
  assign core_rsp_err   = err_q;
  assign warpv_int      = int_q;
  assign transducer_l15_req_ack = rst_n && l15_transducer_val;

  always_comb begin
    transducer_l15_val     = 1'b0;
    transducer_l15_rqtype  = '0;
    transducer_l15_size    = '0;
    transducer_l15_address = '0;
    transducer_l15_data    = '0;
    transducer_l15_nc      = 1'b0;
    transducer_l15_amo_op  = '0;
    if (state == S_REQ) begin
      transducer_l15_val     = 1'b1;
      transducer_l15_address = paddr;
      transducer_l15_nc      = addr_q[NC_BIT] | is_amo;
      transducer_l15_amo_op  = amo_fwd;
      if (wstrb_q == '0) begin
        transducer_l15_rqtype = LOAD_RQ;
        transducer_l15_size   = (XLEN == 32) ? 3'b011 : 3'b100;
      end else begin
        transducer_l15_rqtype = is_amo ? SWAP_RQ : STORE_RQ;
        transducer_l15_size   = q_dec[2:0];
        transducer_l15_data   = st_word;
      end
    end
  end

  assign transducer_l15_threadid             = 1'b0;
  assign transducer_l15_prefetch             = 1'b0;
  assign transducer_l15_invalidate_cacheline = 1'b0;
  assign transducer_l15_blockstore           = 1'b0;
  assign transducer_l15_blockinitstore       = 1'b0;
  assign transducer_l15_l1rplway             = '0;
  assign transducer_l15_data_next_entry      = '0;
  assign transducer_l15_csm_data             = '0;

endmodule

// File: tb/tb_warpv_l15_bridge.sv
// Directed bench for warpv_l15_bridge: XLEN=32 (timeout 16) and XLEN=64.
// Atomic expectations follow `WARPV_L15_AMO_EN.
module tb_warpv_l15_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // shared L1.5 response side
  logic        ack = 0, hack = 0, l15v = 0;
  logic [3:0]  rt = 0;
  logic [63:0] d0 = 0, d1 = 0;

  // XLEN=32 instance
  logic        valid = 0, ready;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0]  wstrb = 0, amo = 0;
  logic        rsp_v, rsp_e;
  logic [31:0] rdata;
  logic        t_val, t_nc, t_tid, t_pf, t_inv, t_bs, t_bis;
  logic [4:0]  t_rq;
  logic [2:0]  t_sz;
  logic [39:0] t_ad;
  logic [63:0] t_dat, t_dne;
  logic [3:0]  t_amo;
  logic [1:0]  t_way;
  logic [32:0] t_csm;
  logic        req_ack, wint;

  // XLEN=64 instance
  logic        w_valid = 0, w_ready;
  logic [63:0] w_addr = 0, w_wdata = 0;
  logic [7:0]  w_wstrb = 0;
  logic [3:0]  w_amo = 0;
  logic        w_rsp_v, w_rsp_e;
  logic [63:0] w_rdata;
  logic        w_val, w_nc, w_tid, w_pf, w_inv, w_bs, w_bis;
  logic [4:0]  w_rq;
  logic [2:0]  w_sz;
  logic [39:0] w_ad;
  logic [63:0] w_dat, w_dne;
  logic [3:0]  w_amo_o;
  logic [1:0]  w_way;
  logic [32:0] w_csm;
  logic        w_req_ack, w_int;

  warpv_l15_bridge #(.XLEN(32), .TIMEOUT_CYCLES(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_valid(valid), .core_req_ready(ready),
    .core_req_addr(addr), .core_req_wdata(wdata),
    .core_req_wstrb(wstrb), .core_req_amo_op(amo),
    .core_rsp_valid(rsp_v), .core_rsp_rdata(rdata),
    .core_rsp_err(rsp_e),
    .transducer_l15_val(t_val), .transducer_l15_rqtype(t_rq),
    .transducer_l15_size(t_sz), .transducer_l15_address(t_ad),
    .transducer_l15_data(t_dat), .transducer_l15_nc(t_nc),
    .transducer_l15_amo_op(t_amo),
    .transducer_l15_threadid(t_tid),
    .transducer_l15_prefetch(t_pf),
    .transducer_l15_invalidate_cacheline(t_inv),
    .transducer_l15_blockstore(t_bs),
    .transducer_l15_blockinitstore(t_bis),
    .transducer_l15_l1rplway(t_way),
    .transducer_l15_data_next_entry(t_dne),
    .transducer_l15_csm_data(t_csm),
    .l15_transducer_ack(ack),
    .l15_transducer_header_ack(hack),
    .l15_transducer_val(l15v),
    .l15_transducer_returntype(rt),
    .l15_transducer_data_0(d0), .l15_transducer_data_1(d1),
    .transducer_l15_req_ack(req_ack), .warpv_int(wint)
  );

  warpv_l15_bridge #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .core_req_valid(w_valid), .core_req_ready(w_ready),
    .core_req_addr(w_addr), .core_req_wdata(w_wdata),
    .core_req_wstrb(w_wstrb), .core_req_amo_op(w_amo),
    .core_rsp_valid(w_rsp_v), .core_rsp_rdata(w_rdata),
    .core_rsp_err(w_rsp_e),
    .transducer_l15_val(w_val), .transducer_l15_rqtype(w_rq),
    .transducer_l15_size(w_sz), .transducer_l15_address(w_ad),
    .transducer_l15_data(w_dat), .transducer_l15_nc(w_nc),
    .transducer_l15_amo_op(w_amo_o),
    .transducer_l15_threadid(w_tid),
    .transducer_l15_prefetch(w_pf),
    .transducer_l15_invalidate_cacheline(w_inv),
    .transducer_l15_blockstore(w_bs),
    .transducer_l15_blockinitstore(w_bis),
    .transducer_l15_l1rplway(w_way),
    .transducer_l15_data_next_entry(w_dne),
    .transducer_l15_csm_data(w_csm),
    .l15_transducer_ack(ack),
    .l15_transducer_header_ack(hack),
    .l15_transducer_val(l15v),
    .l15_transducer_returntype(rt),
    .l15_transducer_data_0(d0), .l15_transducer_data_1(d1),
    .transducer_l15_req_ack(w_req_ack), .warpv_int(w_int)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    valid = 1; addr = a; wdata = d; wstrb = s;
    step();
    valid = 0;
  endtask

  task automatic do_ack();
    ack = 1;
    step();
    ack = 0;
  endtask

  task automatic reply(input logic [3:0] t, input logic [63:0] a,
                       input logic [63:0] b);
    l15v = 1; rt = t; d0 = a; d1 = b;
    step();
    l15v = 0;
  endtask

  initial begin
    logic [3:0] bad [3];
    int k;
    bad[0] = 4'b0101; bad[1] = 4'b0110; bad[2] = 4'b1110;

    step(); step();
    check("rst_ready", ready, 0);
    check("rst_val", t_val, 0);
    check("rst_rsp", rsp_v, 0);
    check("rst_rdata", rdata, 0);
    check("rst_int", wint, 0);
    check("rst_size", t_sz, 0);
    rst_n = 1;
    step();
    check("idle_ready", ready, 1);

    // load at 0x8, ack two cycles later
    issue(32'h8, 0, 0);
    check("ld_ready", ready, 0);
    check("ld_val", t_val, 1);
    check("ld_rq", t_rq, 5'b00000);
    check("ld_size", t_sz, 3'b011);
    check("ld_addr", t_ad, 40'h8);
    check("ld_nc", t_nc, 0);
    check("ld_data", t_dat, 0);
    step();
    check("ld_val_hold", t_val, 1);
    step();
    do_ack();
    check("ld_val_drop", t_val, 0);
    l15v = 1; rt = 4'b0000; d0 = 0;
    d1 = 64'h11223344_AABBCCDD;
    #1 check("ld_req_ack", req_ack, 1);
    step();
    l15v = 0;
    check("ld_rsp_v", rsp_v, 1);
    check("ld_rdata", rdata, 32'h44332211);
    check("ld_err", rsp_e, 0);
    step();
    check("ld_rsp_pulse", rsp_v, 0);
    check("ld_back_idle", ready, 1);

    // halfword store to a non-cacheable address
    issue(32'h8000_0010, 32'h0000_BEEF, 4'b0011);
    check("st_rq", t_rq, 5'b00001);
    check("st_size", t_sz, 3'b010);
    check("st_nc", t_nc, 1);
    check("st_addr", t_ad, 40'hFF_8000_0010);
    check("st_data", t_dat, 64'hEFBE0000_EFBE0000);
    do_ack();
    reply(4'b0100, 64'hFFFF, 64'hFFFF);
    check("st_rsp_v", rsp_v, 1);
    check("st_rdata", rdata, 0);
    check("st_err", rsp_e, 0);
    step();

    // upper halfword and single byte strobes
    issue(32'h20, 32'h1234_5678, 4'b1100);
    check("h1_size", t_sz, 3'b010);
    check("h1_data", t_dat, 64'h78563412_78563412);
    do_ack();
    reply(4'b0100, 0, 0);
    step();
    issue(32'h21, 32'h0, 4'b0100);
    check("b_size", t_sz, 3'b001);
    do_ack();
    reply(4'b0100, 0, 0);
    check("b_rsp_v", rsp_v, 1);
    step();

    // illegal strobes answer with err, no L1.5 traffic
    for (int i = 0; i < 3; i++) begin
      issue(32'h40, 32'h1, bad[i]);
      check("bad_val", t_val, 0);
      check("bad_rsp_v", rsp_v, 1);
      check("bad_err", rsp_e, 1);
      step();
      check("bad_done", rsp_v, 0);
    end

    // timeout after 16 WAIT_RESP cycles
    issue(32'h0, 0, 0);
    do_ack();
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (rsp_v) begin
        k = c;
        break;
      end
    end
    check("to_cycles", k, 16);
    check("to_err", rsp_e, 1);
    check("to_rdata", rdata, 0);
    step();
    reply(4'b0000, 64'h1, 64'h1);
    check("to_stale", rsp_v, 0);
    check("to_stale_rdy", ready, 1);

    // wake-up interrupt while waiting
    issue(32'h4, 0, 0);
    do_ack();
    reply(4'b0111, 64'h2_0000, 0);
    check("int_wrong_bits", wint, 0);
    reply(4'b0111, 64'h1_0000, 0);
    check("int_pulse", wint, 1);
    check("int_no_rsp", rsp_v, 0);
    step();
    check("int_one_cycle", wint, 0);
`ifndef WARPV_L15_AMO_EN
    reply(4'b1110, 64'h1, 0);
    check("amo_res_ignored", rsp_v, 0);
`endif
    reply(4'b0000, 64'h01020304_05060708, 0);
    check("int_ld_rsp", rsp_v, 1);
    check("int_ld_rdata", rdata, 32'h08070605);
    step();

    // reset while a request is outstanding
    issue(32'hC, 0, 0);
    rst_n = 0;
    step();
    check("mrst_val", t_val, 0);
    check("mrst_rsp", rsp_v, 0);
    rst_n = 1;
    step();
    check("mrst_ready", ready, 1);
    reply(4'b0000, 64'h5, 64'h5);
    check("mrst_stale", rsp_v, 0);

    // XLEN=64: doubleword atomic/store
    w_valid = 1; w_addr = 64'h100; w_amo = 4'h1;
    w_wdata = 64'h01020304_05060708; w_wstrb = 8'hFF;
    step();
    w_valid = 0; w_amo = 0;
    check("w_size", w_sz, 3'b100);
    check("w_data", w_dat, 64'h08070605_04030201);
`ifdef WARPV_L15_AMO_EN
    check("w_rq", w_rq, 5'b00110);
    check("w_nc", w_nc, 1);
    check("w_amo", w_amo_o, 4'h1);
    do_ack();
    reply(4'b1110, 64'h11223344_55667788, 0);
    check("w_rsp_v", w_rsp_v, 1);
    check("w_rdata", w_rdata, 64'h88776655_44332211);
`else
    check("w_rq", w_rq, 5'b00001);
    check("w_nc", w_nc, 0);
    check("w_amo", w_amo_o, 4'h0);
    do_ack();
    reply(4'b1110, 64'h11223344_55667788, 0);
    check("w_amo_ignored", w_rsp_v, 0);
    reply(4'b0100, 64'h11223344_55667788, 0);
    check("w_rsp_v", w_rsp_v, 1);
    check("w_rdata", w_rdata, 0);
`endif
    step();

    // XLEN=64 load selects data_1 by addr[3]
    w_valid = 1; w_addr = 64'h8; w_wstrb = 0;
    step();
    w_valid = 0;
    check("w_ld_size", w_sz, 3'b100);
    check("w_ld_rq", w_rq, 5'b00000);
    do_ack();
    reply(4'b0000, 64'hDEAD, 64'h00112233_44556677);
    check("w_ld_rsp", w_rsp_v, 1);
    check("w_ld_rdata", w_rdata, 64'h77665544_33221100);
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/warpv_l15_bridge.md
Name: warpv_l15_bridge

Overview:
- Parametrised successor bridge between a WARP-V core memory port (valid/ready request, valid response) and the OpenPiton L1.5 request/response interface.
- Supports XLEN of 32 or 64, a registered request/response FSM with a single outstanding transaction, store-strobe legality checking, a response timeout, and wake-up interrupt pulse generation.
- Sits between the WARP-V memory stage and the tile's L1.5.

Parameters:
- XLEN, 32, core data width; legal values 32 or 64.
- PHY_ADDR_WIDTH, 40, L1.5 physical address width; core address is sign-extended to this width.
- NC_BIT, XLEN-1, core address bit that marks a non-cacheable access.
- TIMEOUT_CYCLES, 1024, maximum WAIT_RESP cycles before an error response is returned; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- core_req_valid  in  1  core request valid
- core_req_ready  out  1  bridge accepts the request this cycle
- core_req_addr  in  XLEN  byte address
- core_req_wdata  in  XLEN  store data, little-endian
- core_req_wstrb  in  XLEN/8  byte strobes; all zero means a load
- core_req_amo_op  in  4  atomic op; 0 means none
- core_rsp_valid  out  1  one-cycle response pulse
- core_rsp_rdata  out  XLEN  load data, little-endian
- core_rsp_err  out  1  response is an error (illegal strobe or timeout)
- transducer_l15_val  out  1  L1.5 request valid
- transducer_l15_rqtype  out  5  iop.h LOAD_RQ, STORE_RQ or SWAP_RQ
- transducer_l15_size  out  3  1B=001, 2B=010, 4B=011, 8B=100
- transducer_l15_address  out  PHY_ADDR_WIDTH  request address
- transducer_l15_data  out  64  big-endian store data
- transducer_l15_nc  out  1  non-cacheable
- transducer_l15_amo_op  out  4  atomic op
- l15_transducer_ack  in  1  request accepted
- l15_transducer_header_ack  in  1  unused; the bridge keeps it for port compatibility
- l15_transducer_val  in  1  response valid
- l15_transducer_returntype  in  4  response type
- l15_transducer_data_0  in  64  response data word 0
- l15_transducer_data_1  in  64  response data word 1
- transducer_l15_req_ack  out  1  response consumed
- warpv_int  out  1  one-cycle wake-up interrupt pulse
- Remaining unused L1.5 request outputs (threadid, prefetch, invalidate_cacheline, blockstore, blockinitstore, l1rplway, data_next_entry, csm_data) are tied to 0.

Behaviour:
- FSM states: IDLE, REQ, WAIT_RESP, RESP. Reset puts the FSM in IDLE and drives every output to 0.
- IDLE:
  - core_req_ready=1.
  - On core_req_valid, capture addr, wdata, wstrb and amo_op into registers.
  - Legal strobe: go to REQ.
  - Illegal strobe: go to RESP with err=1. No L1.5 traffic is issued.
- Legal strobe definition: all zero, or a contiguous naturally-aligned run of 1, 2, 4 or 8 (XLEN=64 only) bytes.
- Request decode:
  - Size comes from the strobe run length.
  - Loads use size 4B when XLEN=32 and 8B when XLEN=64.
- Address: sign-extended from the captured address. nc = addr[NC_BIT] OR atomic request.
- Store data:
  - Byte-reverse the captured data across XLEN.
  - When XLEN=32, replicate it in both 32-bit halves of transducer_l15_data.
  - Loads drive data 0.
- REQ:
  - transducer_l15_val=1 with all request fields driven from registers and stable.
  - On l15_transducer_ack, go to WAIT_RESP.
  - Val drops in the cycle after ack.
- WAIT_RESP, response with l15_transducer_val=1:
  - LOAD_RET / ST_ACK (plus ATOMIC_RES when atomics are enabled): capture data, go to RESP.
  - INT_RET: no state change.
  - Other types: ignored.
  - transducer_l15_req_ack = l15_transducer_val in every state.
- Load data select:
  - XLEN=32: addr[3:2] selects data_0[63:32], data_0[31:0], data_1[63:32] or data_1[31:0].
  - XLEN=64: addr[3] selects data_0 or data_1.
  - The selected word is byte-reversed. ST_ACK returns rdata=0.
- Timeout:
  - A cycle counter runs in WAIT_RESP.
  - Reaching TIMEOUT_CYCLES goes to RESP with err=1 and rdata=0.
  - A later stale response is ignored by IDLE.
- RESP: core_rsp_valid=1 for exactly one cycle, then IDLE. Earliest load-to-response latency is ack+1 cycles.
- Interrupt: INT_RET with data_0[17:16]==2'b01 in any state produces a one-cycle warpv_int pulse, registered (one cycle later). It coincides with normal flow without disturbing it.
- Reset mid-transaction: the FSM returns to IDLE immediately. The outstanding L1.5 response is dropped by IDLE.

Optional Feature:
- Macro: WARPV_L15_AMO_EN.
- Defined: a nonzero core_req_amo_op with a legal store strobe issues SWAP_RQ, nc=1, and amo_op is forwarded. A CPX ATOMIC_RES (4'b1110) response completes the request with load-style data.
- Undefined: amo_op is ignored (the request is a plain store), transducer_l15_amo_op=0, and ATOMIC_RES is treated as an unknown type.

Test Plan:
- XLEN=32 load at 0x0000_0008: ack after 2 cycles, then LOAD_RET with data_1=0x11223344_AABBCCDD -> rqtype LOAD_RQ, size 011, rsp rdata=0x44332211, err=0.
- XLEN=32 store wstrb=4'b0011, wdata=0x0000BEEF, addr 0x8000_0010 -> size 010, nc=1, address 0xFF_8000_0010, data=0xEFBE0000_EFBE0000; ST_ACK -> rsp_valid pulse, rdata=0.
- Illegal wstrb=4'b0101 -> no transducer_l15_val, rsp err=1 one cycle after accept.
- TIMEOUT_CYCLES=16, no response -> err=1 on cycle 16 of WAIT_RESP; a later LOAD_RET is ignored.
- INT_RET with data_0[17:16]=01 during WAIT_RESP -> warpv_int high exactly one cycle; a subsequent LOAD_RET still completes.
- XLEN=64 with WARPV_L15_AMO_EN, amo_op=4'h1, wstrb=8'hFF -> rqtype SWAP_RQ, size 100, nc=1; ATOMIC_RES returns byte-reversed data_0.
